wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: ALU writeback queue entries.
REQ-002 Parameter W_REG, default 6'd34: working-register index targeted by memory loads.
REQ-003 Parameter NULL_REG, default 6'd35: "no write" register index.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 alu_valid  in  1  ALU writeback request this cycle.
REQ-007 alu_sel  in  6  ALU destination register.
REQ-008 alu_data  in  16  ALU result.
REQ-009 alu_stall  out  1  queue full; upstream holds its request.
REQ-010 mem_valid  in  1  load data return this cycle (MR completion).
REQ-011 mem_data  in  16  loaded word, destined for W_REG.
REQ-012 rf_we  out  1  register-file write enable.
REQ-013 rf_sel  out  6  register-file write index.
REQ-014 rf_data  out  16  register-file write data.
REQ-015 pending  out  2  live-or-killed queue occupancy, 0..DEPTH.

Function
REQ-016 rf_we, rf_sel and rf_data SHALL be registered, with exactly one cycle of latency from the winning request to the write.
REQ-017 mem_valid SHALL win the write port unconditionally: next cycle rf_we=1, rf_sel=W_REG, rf_data=mem_data.
REQ-018 An ALU request SHALL be accepted when alu_valid=1 and alu_stall=0; accepting it while alu_stall=1 is forbidden.
REQ-019 An accepted request with alu_sel=NULL_REG SHALL be consumed without being queued or written.
REQ-020 When mem_valid=0, the queue is empty and an ALU request is accepted, it SHALL bypass the queue: next cycle rf_we=1 with alu_sel/alu_data.
REQ-021 When mem_valid=0 and the queue is non-empty, the head SHALL pop to the port, and a same-cycle accepted request SHALL push to the tail (FIFO order preserved).
REQ-022 When mem_valid=1, any accepted ALU request SHALL be pushed; no pop occurs that cycle.
REQ-023 The occupancy state SHALL be EMPTY (count 0), PART (0<count<DEPTH) or FULL (count=DEPTH).
REQ-024 Occupancy transitions SHALL be +1 on push only, -1 on pop only, and unchanged on push+pop or idle.
REQ-025 alu_stall SHALL equal (count==DEPTH), decoded from registered count only.
REQ-026 WAW kill: on mem_valid=1, every queued entry with sel=W_REG, and a same-cycle accepted ALU request to W_REG, SHALL be marked killed.
REQ-027 A killed entry reaching the head SHALL pop with rf_we=0 for that cycle.
REQ-028 When no write is issued in a cycle, rf_we SHALL be 0 and rf_sel/rf_data SHALL hold their previous values.
REQ-029 pending SHALL equal count, including killed entries.

Reset
REQ-030 reset=1 SHALL asynchronously clear count, all valid/kill bits, rf_we=0, rf_sel=NULL_REG, rf_data=16'h0000, alu_stall=0 and pending=0.
REQ-031 Queued writes in flight at reset SHALL be discarded without being written.
REQ-032 The first write SHALL be possible in the first cycle after reset deasserts.

Structure
REQ-033 W_REG, NULL_REG, the data width (16), the select width (6) and the occupancy-state encoding SHALL live in the shared CPU package.
REQ-034 The queue SHALL be one sub-module, wb_queue (push, pop, kill-by-index, head, count); wb_arbiter holds the arbitration and output registers.

Verification
REQ-035 After reset, a single ALU write (alu_sel=5, data=16'h1234) with mem idle -> one cycle later rf_we=1, rf_sel=5, rf_data=16'h1234; pending stays 0.
REQ-036 mem_valid=1 (data=16'hBEEF) with alu_valid=1 (sel=7, data=16'h0001) -> cycle+1 writes 34/BEEF; cycle+2 writes 7/0001.
REQ-037 Three ALU writes during three mem_valid cycles -> alu_stall=1 after two pushes; the third is held; pending=2; queued writes drain in order afterward.
REQ-038 Queue holds a write to sel=34 (data=16'hAAAA) when mem_valid=1 arrives (data=16'h5555) -> 34/5555 is written; the popped killed entry gives rf_we=0; 16'hAAAA is never written.
REQ-039 alu_sel=35 request -> no write is produced and pending is unchanged.
REQ-040 reset is asserted mid-drain with pending=2 -> immediately rf_we=0 and pending=0, and no stale write appears after release.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - register-file writeback widths, special indices and occupancy encoding
package wb_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 6;

    localparam logic [SEL_W-1:0] W_REG_IDX    = 6'd34;
    localparam logic [SEL_W-1:0] NULL_REG_IDX = 6'd35;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_PART  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - shifting writeback queue with per-entry kill by destination index
module wb_queue
    import wb_arbiter_pkg::*;
#(
    parameter int               DEPTH = 2,
    parameter logic [SEL_W-1:0] W_REG = W_REG_IDX,
    localparam int              CNT_W = $clog2(DEPTH + 1),
    localparam int              IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              push_kill,
    input  logic [SEL_W-1:0]  push_sel,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              kill,
    output logic [SEL_W-1:0]  head_sel,
    output logic [DATA_W-1:0] head_data,
    output logic              head_kill,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0]  vld_q, vld_d, kil_q, kil_d;
    logic [SEL_W-1:0]  sel_q [DEPTH];
    logic [SEL_W-1:0]  sel_d [DEPTH];
    logic [DATA_W-1:0] dat_q [DEPTH];
    logic [DATA_W-1:0] dat_d [DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  wr_idx;
    occ_t              occ_q, occ_d;

    // Kill is applied before the shift so a same-cycle pop still carries the mark.
    always_comb begin
        vld_d  = vld_q;
        kil_d  = kil_q;
        sel_d  = sel_q;
        dat_d  = dat_q;
        cnt_d  = cnt_q;
        wr_idx = IDX_W'(cnt_q);
        if (kill) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_q[i] && sel_q[i] == W_REG) kil_d[i] = 1'b1;
            end
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                vld_d[i] = vld_d[i+1];
                kil_d[i] = kil_d[i+1];
                sel_d[i] = sel_d[i+1];
                dat_d[i] = dat_d[i+1];
            end
            vld_d[DEPTH-1] = 1'b0;
            kil_d[DEPTH-1] = 1'b0;
            wr_idx = IDX_W'(cnt_q - CNT_W'(1));
        end
        if (push) begin
            vld_d[wr_idx] = 1'b1;
            kil_d[wr_idx] = push_kill;
            sel_d[wr_idx] = push_sel;
            dat_d[wr_idx] = push_data;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (cnt_d == '0)            occ_d = OCC_EMPTY;
        else if (cnt_d == FULL_CNT) occ_d = OCC_FULL;
        else                        occ_d = OCC_PART;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            kil_q <= '0;
            cnt_q <= '0;
            occ_q <= OCC_EMPTY;
            for (int i = 0; i < DEPTH; i++) begin
                sel_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            kil_q <= kil_d;
            cnt_q <= cnt_d;
            occ_q <= occ_d;
            sel_q <= sel_d;
            dat_q <= dat_d;
        end
    end

    assign head_sel  = sel_q[0];
    assign head_data = dat_q[0];
    assign head_kill = kil_q[0];
    assign count     = cnt_q;
    assign empty     = (occ_q == OCC_EMPTY);
    assign full      = (occ_q == OCC_FULL);

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write port arbitration between load returns and queued ALU results
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int               DEPTH    = 2,
    parameter logic [SEL_W-1:0] W_REG    = W_REG_IDX,
    parameter logic [SEL_W-1:0] NULL_REG = NULL_REG_IDX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_stall,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic              rf_we,
    output logic [SEL_W-1:0]  rf_sel,
    output logic [DATA_W-1:0] rf_data,
    output logic [1:0]        pending
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              q_push, q_push_kill, q_pop, q_kill;
    logic [SEL_W-1:0]  q_head_sel;
    logic [DATA_W-1:0] q_head_data;
    logic              q_head_kill, q_empty, q_full;
    logic [CNT_W-1:0]  q_count;
    logic              accept, alu_live, we_d;
    logic [SEL_W-1:0]  sel_d;
    logic [DATA_W-1:0] data_d;

    wb_queue #(.DEPTH(DEPTH), .W_REG(W_REG)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .push_kill (q_push_kill),
        .push_sel  (alu_sel),
        .push_data (alu_data),
        .pop       (q_pop),
        .kill      (q_kill),
        .head_sel  (q_head_sel),
        .head_data (q_head_data),
        .head_kill (q_head_kill),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    assign alu_stall = q_full;
    assign pending   = 2'(q_count);
    assign accept    = alu_valid & ~alu_stall;
    assign alu_live  = accept & (alu_sel != NULL_REG);

    // Load returns own the port; otherwise the queue head goes before any new request.
    always_comb begin
        q_push      = 1'b0;
        q_push_kill = 1'b0;
        q_pop       = 1'b0;
        q_kill      = 1'b0;
        we_d        = 1'b0;
        sel_d       = alu_sel;
        data_d      = alu_data;
        if (mem_valid) begin
            we_d        = 1'b1;
            sel_d       = W_REG;
            data_d      = mem_data;
            q_kill      = 1'b1;
            q_push      = alu_live;
            q_push_kill = (alu_sel == W_REG);
        end else if (!q_empty) begin
            q_pop  = 1'b1;
            q_push = alu_live;
            we_d   = ~q_head_kill;
            sel_d  = q_head_sel;
            data_d = q_head_data;
        end else if (alu_live) begin
            we_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we   <= 1'b0;
            rf_sel  <= NULL_REG;
            rf_data <= '0;
        end else begin
            rf_we <= we_d;
            if (we_d) begin
                rf_sel  <= sel_d;
                rf_data <= data_d;
            end
        end
    end

endmodule
